// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpOr  = 3'b010,
        OpAnd = 3'b011,
        OpShl = 3'b100,
        OpShr = 3'b101,
        OpRol = 3'b110,
        OpRor = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } alu_state_e;

    // Shift/rotate opcodes all have the top opcode bit set.
    function automatic logic is_shift_op(input alu_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ADD/SUB/OR/AND datapath with carry/borrow and signed-overflow flags.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned Msb = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        diff   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        result = a;
        cout   = 1'b0;
        ovf    = 1'b0;
        case (op)
            OpAdd: begin
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
                ovf    = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
            end
            OpSub: begin
                // diff[WIDTH] is set exactly when a < b + cin
                result = diff[WIDTH-1:0];
                cout   = diff[WIDTH];
                ovf    = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
            end
            OpOr:    result = a | b;
            OpAnd:   result = a & b;
            // Shift opcodes reaching here have a zero amount: pass A through.
            default: result = a;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, bit-serial shifts and rotates,
// valid/ready handshake on both sides with one request in flight.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Cout,
    output logic             Zero,
    output logic             Ovf
);

    localparam int unsigned SW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    alu_op_e          req_op;
    logic [SW-1:0]    req_amt;
    logic [WIDTH-1:0] core_res;
    logic             core_cout;
    logic             core_ovf;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;

    assign req_op  = alu_op_e'(Ctrl);
    assign req_amt = B[SW-1:0];

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (A),
        .b      (B),
        .cin    (Cin),
        .op     (req_op),
        .result (core_res),
        .cout   (core_cout),
        .ovf    (core_ovf)
    );

    // One bit position per cycle; step_bit is the bit leaving a logical shift.
    always_comb begin
        step_val = work_q;
        step_bit = 1'b0;
        case (op_q)
            OpShl: begin
                step_val = {work_q[WIDTH-2:0], 1'b0};
                step_bit = work_q[WIDTH-1];
            end
            OpShr: begin
                step_val = {1'b0, work_q[WIDTH-1:1]};
                step_bit = work_q[0];
            end
            OpRol:   step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            OpRor:   step_val = {work_q[0], work_q[WIDTH-1:1]};
            default: step_val = work_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d   = req_op;
                    work_d = A;
                    cnt_d  = req_amt;
                    if (is_shift_op(req_op) && (req_amt != '0)) begin
                        state_d = StShift;
                    end else begin
                        out_d   = core_res;
                        cout_d  = core_cout;
                        ovf_d   = core_ovf;
                        zero_d  = (core_res == '0);
                        state_d = StDone;
                    end
                end
            end
            StShift: begin
                work_d = step_val;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SW'(1)) begin
                    out_d   = step_val;
                    cout_d  = step_bit;
                    ovf_d   = 1'b0;
                    zero_d  = (step_val == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpAdd;
            work_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Out  = out_q;
    assign Cout = cout_q;
    assign Zero = zero_q;
    assign Ovf  = ovf_q;

endmodule
